// File: rtl/alu_logic_arbiter_pkg.sv
// Types for alu_logic_arbiter: FSM states, register struct and its reset value.
// ALU_LOGIC_ARB_ROUND_ROBIN_EN adds the round-robin pointer to the register.
`timescale 1ns/1ps
package alu_logic_arbiter_pkg;

    import river_cfg_pkg::*;

    // Wide enough for the largest requester count (8).
    localparam int ARB_IDW = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        arb_state_e              state;
        logic [ARB_IDW-1:0]      pend_id;
        logic [ARB_IDW-1:0]      resp_id;
        logic [RISCV_ARCH-1:0]   resp_res;
`ifdef ALU_LOGIC_ARB_ROUND_ROBIN_EN
        logic [ARB_IDW-1:0]      rr_ptr;
`endif
    } arb_reg_t;

    // IDLE encodes as zero, so all-zero is the complete reset image.
    localparam arb_reg_t ARB_REG_RESET = '0;

endpackage

// File: rtl/river_cfg_pkg.sv
// Core-wide configuration constants shared by the RIVER datapath blocks.
`timescale 1ns/1ps
package river_cfg_pkg;

    localparam int RISCV_ARCH = 64;

endpackage

// File: rtl/alu_logic_arbiter_alu_logic.sv
// AluLogic: registered bitwise AND/OR/XOR unit, OR has priority over XOR over AND.
`timescale 1ns/1ps
module AluLogic
    import river_cfg_pkg::*;
#(
    parameter bit async_reset = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic [2:0]            i_mode,
    input  logic [RISCV_ARCH-1:0] i_a1,
    input  logic [RISCV_ARCH-1:0] i_a2,
    output logic [RISCV_ARCH-1:0] o_res
);

    logic [RISCV_ARCH-1:0] r_res;
    logic [RISCV_ARCH-1:0] w_res;

    always_comb begin
        w_res = i_a1 & i_a2;
        if (i_mode[1]) begin
            w_res = i_a1 | i_a2;
        end else if (i_mode[2]) begin
            w_res = i_a1 ^ i_a2;
        end else if (i_mode[0] || i_mode == 3'b000) begin
            w_res = i_a1 & i_a2;
        end
    end

    generate
        if (async_reset) begin : g_async
            always_ff @(posedge i_clk or negedge i_nrst) begin
                if (!i_nrst) begin
                    r_res <= '0;
                end else begin
                    r_res <= w_res;
                end
            end
        end else begin : g_sync
            always_ff @(posedge i_clk) begin
                if (!i_nrst) begin
                    r_res <= '0;
                end else begin
                    r_res <= w_res;
                end
            end
        end
    endgenerate

    assign o_res = r_res;

endmodule

// File: rtl/alu_logic_arbiter.sv
// Shares one AluLogic unit among NREQ requesters with an IDLE/EXEC/RESP handshake.
// Define ALU_LOGIC_ARB_ROUND_ROBIN_EN for round-robin grants; otherwise fixed priority.
`timescale 1ns/1ps
module alu_logic_arbiter
    import river_cfg_pkg::*;
    import alu_logic_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NREQ-1:0]                 i_req_valid,
    input  logic [NREQ-1:0][2:0]            i_req_mode,
    input  logic [NREQ-1:0][RISCV_ARCH-1:0] i_req_a1,
    input  logic [NREQ-1:0][RISCV_ARCH-1:0] i_req_a2,
    output logic [NREQ-1:0]                 o_req_ready,
    output logic                            o_resp_valid,
    output logic [IDW-1:0]                  o_resp_id,
    output logic [RISCV_ARCH-1:0]           o_resp_res,
    input  logic                            i_resp_ready
);

    arb_reg_t              r_st;
    arb_reg_t              w_st_next;
    logic                  w_found;
    logic [IDW-1:0]        w_win;
    logic [2:0]            w_mode;
    logic [RISCV_ARCH-1:0] w_a1;
    logic [RISCV_ARCH-1:0] w_a2;
    logic [RISCV_ARCH-1:0] w_alu_res;
    logic                  w_nrst;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
`ifdef ALU_LOGIC_ARB_ROUND_ROBIN_EN
        // First valid index scanning upward from the pointer, wrapping at NREQ.
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && i_req_valid[(int'(r_st.rr_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_st.rr_ptr) + k) % NREQ);
            end
        end
`else
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req_valid[k]) begin
                w_found = 1'b1;
                w_win   = IDW'(k);
            end
        end
`endif
    end

    assign w_mode = i_req_mode[w_win];
    assign w_a1   = i_req_a1[w_win];
    assign w_a2   = i_req_a2[w_win];

    always_comb begin
        o_req_ready = '0;
        if (!i_rst && r_st.state == IDLE && w_found) begin
            o_req_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_st_next = r_st;
        case (r_st.state)
            IDLE: begin
                if (w_found) begin
                    w_st_next.pend_id = ARB_IDW'(w_win);
`ifdef ALU_LOGIC_ARB_ROUND_ROBIN_EN
                    w_st_next.rr_ptr  = ARB_IDW'((int'(w_win) + 1) % NREQ);
`endif
                    w_st_next.state   = EXEC;
                end
            end
            EXEC: begin
                w_st_next.resp_id  = r_st.pend_id;
                w_st_next.resp_res = w_alu_res;
                w_st_next.state    = RESP;
            end
            RESP: begin
                if (i_resp_ready) begin
                    w_st_next.state = IDLE;
                end
            end
            default: begin
                w_st_next.state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_st <= ARB_REG_RESET;
        end else begin
            r_st <= w_st_next;
        end
    end

    assign w_nrst = ~i_rst;

    AluLogic #(
        .async_reset(1'b1)
    ) u_alu_logic (
        .i_clk (i_clk),
        .i_nrst(w_nrst),
        .i_mode(w_mode),
        .i_a1  (w_a1),
        .i_a2  (w_a2),
        .o_res (w_alu_res)
    );

    assign o_resp_valid = (r_st.state == RESP);
    assign o_resp_id    = r_st.resp_id[IDW-1:0];
    assign o_resp_res   = r_st.resp_res;

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Directed-vector bench for alu_logic_arbiter; grant expectations follow
// ALU_LOGIC_ARB_ROUND_ROBIN_EN.
`timescale 1ns/1ps
module tb_alu_logic_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = river_cfg_pkg::RISCV_ARCH;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic [NREQ-1:0]        i_req_valid;
    logic [NREQ-1:0][2:0]   i_req_mode;
    logic [NREQ-1:0][W-1:0] i_req_a1;
    logic [NREQ-1:0][W-1:0] i_req_a2;
    logic [NREQ-1:0]        o_req_ready;
    logic                   o_resp_valid;
    logic [IDW-1:0]         o_resp_id;
    logic [W-1:0]           o_resp_res;
    logic                   i_resp_ready;

    int n_checks = 0;
    int n_pass   = 0;

    alu_logic_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_mode  (i_req_mode),
        .i_req_a1    (i_req_a1),
        .i_req_a2    (i_req_a2),
        .o_req_ready (o_req_ready),
        .o_resp_valid(o_resp_valid),
        .o_resp_id   (o_resp_id),
        .o_resp_res  (o_resp_res),
        .i_resp_ready(i_resp_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mid();
        @(negedge i_clk);
    endtask

    task automatic run_op(input string tag, input int id, input logic [2:0] mode,
                          input logic [63:0] a1, input logic [63:0] a2,
                          input logic [63:0] exp_res);
        cyc();
        i_req_valid      = '0;
        i_req_valid[id]  = 1'b1;
        i_req_mode[id]   = mode;
        i_req_a1[id]     = a1;
        i_req_a2[id]     = a2;
        i_resp_ready     = 1'b1;
        mid();
        check({tag, ".ready"}, 64'(o_req_ready), 64'(1) << id);
        cyc();
        i_req_valid = '0;
        mid();
        check({tag, ".exec_valid"}, 64'(o_resp_valid), 64'd0);
        cyc();
        mid();
        check({tag, ".valid"}, 64'(o_resp_valid), 64'd1);
        check({tag, ".id"}, 64'(o_resp_id), 64'(id));
        check({tag, ".res"}, o_resp_res, exp_res);
        cyc();
        mid();
        check({tag, ".idle"}, 64'(o_resp_valid), 64'd0);
    endtask

    initial begin
        int exp_idx;
        int waited;

        i_rst        = 1'b1;
        i_req_valid  = '1;
        i_req_mode   = '0;
        i_req_a1     = '0;
        i_req_a2     = '0;
        i_resp_ready = 1'b0;
        cyc();
        mid();
        check("rst.ready", 64'(o_req_ready), 64'd0);
        check("rst.valid", 64'(o_resp_valid), 64'd0);
        check("rst.id", 64'(o_resp_id), 64'd0);
        check("rst.res", o_resp_res, 64'd0);
        cyc();
        i_rst       = 1'b0;
        i_req_valid = '0;

        run_op("or", 0, 3'b010, 64'hF0, 64'h0F, 64'hFF);
        run_op("or_wins", 1, 3'b110, 64'hFF00, 64'h0FF0, 64'hFFF0);
        run_op("and", 2, 3'b000, 64'hFF00, 64'h0FF0, 64'h0F00);
        run_op("xor", 3, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555,
               64'hAAAA_AAAA_AAAA_AAAA);

        // Back-pressure: result held while the consumer stalls; requests ignored.
        cyc();
        i_req_valid    = 4'b0100;
        i_req_mode[2]  = 3'b001;
        i_req_a1[2]    = 64'h1234;
        i_req_a2[2]    = 64'hFF0F;
        i_resp_ready   = 1'b0;
        mid();
        check("stall.ready", 64'(o_req_ready), 64'h4);
        cyc();
        i_req_valid = '1;
        mid();
        check("stall.exec_ready", 64'(o_req_ready), 64'd0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            mid();
            check("stall.valid", 64'(o_resp_valid), 64'd1);
            check("stall.id", 64'(o_resp_id), 64'd2);
            check("stall.res", o_resp_res, 64'h1204);
            check("stall.ready_low", 64'(o_req_ready), 64'd0);
            cyc();
        end
        i_resp_ready = 1'b1;
        i_req_valid  = '0;
        mid();
        check("stall.still_valid", 64'(o_resp_valid), 64'd1);
        cyc();
        mid();
        check("stall.released", 64'(o_resp_valid), 64'd0);

        // Reset during EXEC after the pointer has moved past 0.
        cyc();
        i_req_valid   = 4'b0010;
        i_req_mode[1] = 3'b010;
        i_req_a1[1]   = 64'h1;
        i_req_a2[1]   = 64'h2;
        mid();
        check("rstx.grant", 64'(o_req_ready), 64'h2);
        cyc();
        i_req_valid = '1;
        i_rst       = 1'b1;
        mid();
        check("rstx.ready", 64'(o_req_ready), 64'd0);
        check("rstx.valid", 64'(o_resp_valid), 64'd0);
        check("rstx.id", 64'(o_resp_id), 64'd0);
        check("rstx.res", o_resp_res, 64'd0);
        cyc();
        i_rst       = 1'b0;
        i_req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            mid();
            check("rstx.no_resp", 64'(o_resp_valid), 64'd0);
            cyc();
        end

        // All requesters valid continuously.
        for (int i = 0; i < NREQ; i++) begin
            i_req_mode[i] = 3'b000;
            i_req_a1[i]   = 64'(32'h100 * (i + 1));
            i_req_a2[i]   = 64'(32'h100 * (i + 1));
        end
        i_req_valid  = '1;
        i_resp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
`ifdef ALU_LOGIC_ARB_ROUND_ROBIN_EN
            exp_idx = g % NREQ;
`else
            exp_idx = 0;
`endif
            waited = 0;
            mid();
            while (o_req_ready == '0 && waited < 8) begin
                cyc();
                mid();
                waited++;
            end
            check("all.grant", 64'(o_req_ready), 64'(1) << exp_idx);
            cyc();
            mid();
            cyc();
            mid();
            check("all.valid", 64'(o_resp_valid), 64'd1);
            check("all.id", 64'(o_resp_id), 64'(exp_idx));
            check("all.res", o_resp_res, 64'(32'h100 * (exp_idx + 1)));
            cyc();
        end
        i_req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_logic_arbiter.md
ALU_LOGIC_ARBITER -- requirements
Module: alu_logic_arbiter

Interface
REQ-001 Parameter: NREQ, default 4, number of requesters sharing one logic unit (legal range 2..8).
REQ-002 Parameter: IDW, default 2, requester-id width, equal to $clog2(NREQ).
REQ-003 i_clk  in  1  CPU clock, all state on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_req_valid  in  NREQ  per-requester operation request.
REQ-006 i_req_mode  in  NREQx3  per-requester mode: [0]=AND, [1]=OR, [2]=XOR.
REQ-007 i_req_a1, i_req_a2  in  NREQxRISCV_ARCH  per-requester operands.
REQ-008 o_req_ready  out  NREQ  one-hot grant/accept strobe.
REQ-009 o_resp_valid  out  1  result available.
REQ-010 o_resp_id  out  IDW  index of the requester owning the result.
REQ-011 o_resp_res  out  RISCV_ARCH  result value.
REQ-012 i_resp_ready  in  1  consumer accepts result.

Function
REQ-013 FSM states: IDLE, EXEC, RESP.
REQ-014 IDLE: with any i_req_valid set, the block shall assert o_req_ready for exactly one winner, drive the winner's mode/operands into the logic unit and go to EXEC; with none set it shall stay in IDLE and o_req_ready=0.
REQ-015 o_req_ready is combinational from state/i_req_valid/pointer and is 0 outside IDLE; acceptance is valid&ready in the same cycle.
REQ-016 The winner's index is registered as the pending id in the accept cycle.
REQ-017 EXEC: the registered logic-unit result is captured into the response register with the pending id, then the FSM goes to RESP (fixed 1 cycle).
REQ-018 RESP: o_resp_valid=1 and o_resp_id/o_resp_res stay stable until i_resp_ready=1; on that cycle the FSM goes to IDLE.
REQ-019 Latency: accept in cycle T gives o_resp_valid=1 in cycle T+2; maximum throughput is one operation per 3 cycles.
REQ-020 Mode priority: OR if [1] set, else XOR if [2] set, else AND (mode 3'b000 gives AND); full RISCV_ARCH width, no sign or width change.
REQ-021 A requester dropping i_req_valid before grant is simply not considered; no request is queued inside the block.
REQ-022 i_req_valid asserted in EXEC/RESP is ignored until the next IDLE cycle.
REQ-023 i_resp_ready outside RESP has no effect.

Reset
REQ-024 i_rst=1 shall immediately force: state=IDLE, o_resp_valid=0, o_resp_id=0, o_resp_res=0, pending id=0, round-robin pointer=0, o_req_ready=0 while asserted.
REQ-025 Reset in EXEC or RESP discards the in-flight operation; no response is produced for it after reset release.

Configuration
REQ-026 Macro ALU_LOGIC_ARB_ROUND_ROBIN_EN defined: the winner is the first valid index at or after the pointer (wrapping from NREQ-1 to 0), and on each grant the pointer becomes winner+1 modulo NREQ.
REQ-027 Macro undefined: fixed priority, lowest valid index wins, and no pointer register exists.

Structure
REQ-028 Package alu_logic_arbiter_pkg shall hold the state enum (IDLE, EXEC, RESP), the register struct, and its reset constant.
REQ-029 RISCV_ARCH comes from river_cfg_pkg.
REQ-030 One sub-module: the existing AluLogic unit, instantiated with async_reset=1, nrst driven by the inverse of i_rst.
REQ-031 Arbitration and mux logic stay inline.

Verification
REQ-032 Req0 mode=010, a1=0xF0, a2=0x0F, resp_ready=1 -> ready[0] in T, resp valid in T+2 with id=0, res=0xFF, IDLE in T+3.
REQ-033 Mode=110, a1=0xFF00, a2=0x0FF0 -> res=0xFFF0 (OR wins); mode=000, same operands -> res=0x0F00.
REQ-034 RR build, all 4 valid continuously -> grants 0,1,2,3,0 in order; fixed build -> grants always 0.
REQ-035 i_resp_ready held 0 for 5 cycles in RESP -> id/res stable, no ready pulses; ready=1 -> IDLE on the next edge.
REQ-036 i_rst pulsed during EXEC -> no response after release, all outputs 0, and the next grant goes to index 0 (RR).
REQ-037 Req3 mode=100, a1=all ones, a2=0x5555_5555_5555_5555 -> res=0xAAAA_AAAA_AAAA_AAAA, id=3.
